// File: rtl/wb_decompressor.sv
// ============================================================================
// Module   : wb_decompressor
// Purpose  : Slave-side endpoint of the compressed wishbone link. Rebuilds a
//            wishbone master cycle (single, 4-beat or 8-beat burst) from
//            serialized 16-bit link words and returns read data plus
//            ack/err status over the link.
// Ports    : i_clk, i_rst        - link clock, synchronous active-high reset
//            cw_io_i / cw_io_o   - link request words in / read data out
//            cw_req, cw_dir      - link transaction open / master driving
//            cw_ack, cw_err      - one-cycle beat-complete / error pulses
//            wb_*                - wishbone master interface to peripherals
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_decompressor #(
  parameter int RW        = 16,
  parameter int WB_ADDR_W = 24
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [RW-1:0]        cw_io_i,
  output logic [RW-1:0]        cw_io_o,
  input  logic                 cw_req,
  input  logic                 cw_dir,
  output logic                 cw_ack,
  output logic                 cw_err,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  output logic [WB_ADDR_W-1:0] wb_adr,
  output logic [RW-1:0]        wb_o_dat,
  input  logic [RW-1:0]        wb_i_dat,
  output logic [1:0]           wb_sel,
  output logic                 wb_4_burst,
  output logic                 wb_8_burst,
  input  logic                 wb_ack,
  input  logic                 wb_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_RESP  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t               r_state, w_state;
  logic [RW-1:0]        r_adr_lo, w_adr_lo;
  logic [3:0]           r_beats, w_beats;
  logic                 r_cyc, w_cyc;
  logic                 r_stb, w_stb;
  logic                 r_we, w_we;
  logic [WB_ADDR_W-1:0] r_adr, w_adr;
  logic [RW-1:0]        r_odat, w_odat;
  logic [1:0]           r_sel, w_sel;
  logic                 r_b4, w_b4;
  logic                 r_b8, w_b8;
  logic [RW-1:0]        r_rdat, w_rdat;
  logic                 r_ack, w_ack;
  logic                 r_err, w_err;
  logic                 w_take;
  logic [2:0]           w_unused_rsv;

  // Reserved header bits carry no meaning.
  assign w_unused_rsv = cw_io_i[10:8];
  assign w_take       = cw_req & cw_dir;

  always_comb begin
    w_state  = r_state;
    w_adr_lo = r_adr_lo;
    w_beats  = r_beats;
    w_cyc    = r_cyc;
    w_stb    = r_stb;
    w_we     = r_we;
    w_adr    = r_adr;
    w_odat   = r_odat;
    w_sel    = r_sel;
    w_b4     = r_b4;
    w_b8     = r_b8;
    w_rdat   = r_rdat;
    w_ack    = 1'b0;
    w_err    = 1'b0;

    if (r_state != S_IDLE && !cw_req) begin
      // Abort: the master closed the transaction. Everything toward the
      // bus is cleared and any concurrent slave response is discarded.
      w_state = S_IDLE;
      w_beats = 4'd0;
      w_cyc   = 1'b0;
      w_stb   = 1'b0;
      w_we    = 1'b0;
      w_adr   = '0;
      w_odat  = '0;
      w_sel   = 2'b00;
      w_b4    = 1'b0;
      w_b8    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cyc = 1'b0;
          w_stb = 1'b0;
          if (w_take) begin
            w_adr_lo = cw_io_i;
            w_state  = S_HDR;
          end
        end
        S_HDR: begin
          if (w_take) begin
            w_we    = cw_io_i[15];
            w_b8    = cw_io_i[14];
            w_b4    = cw_io_i[13];
            w_sel   = cw_io_i[12:11];
            w_adr   = {cw_io_i[WB_ADDR_W-RW-1:0], r_adr_lo};
            // b8 takes precedence when both hints are set.
            w_beats = cw_io_i[14] ? 4'd8 : (cw_io_i[13] ? 4'd4 : 4'd1);
            if (cw_io_i[15]) begin
              w_state = S_WDATA;
            end else begin
              w_state = S_BUS;
              w_cyc   = 1'b1;
              w_stb   = 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (w_take) begin
            w_odat  = cw_io_i;
            w_state = S_BUS;
            w_cyc   = 1'b1;
            w_stb   = 1'b1;
          end
        end
        S_BUS: begin
          // Error has priority over a simultaneous ack.
          if (wb_err) begin
            w_state = S_ERR;
            w_cyc   = 1'b0;
            w_stb   = 1'b0;
            w_err   = 1'b1;
          end else if (wb_ack) begin
            w_rdat  = wb_i_dat;
            w_beats = r_beats - 4'd1;
            w_state = S_RESP;
            w_stb   = 1'b0;
            w_ack   = 1'b1;
          end
        end
        S_RESP: begin
          if (r_beats != 4'd0) begin
            w_adr = r_adr + WB_ADDR_W'(1);
            if (r_we) begin
              w_state = S_WDATA;
            end else begin
              w_state = S_BUS;
              w_stb   = 1'b1;
            end
          end else begin
            w_state = S_IDLE;
            w_cyc   = 1'b0;
          end
        end
        S_ERR: begin
          w_state = S_IDLE;
          w_beats = 4'd0;
        end
        default: begin
          w_state = S_IDLE;
          w_cyc   = 1'b0;
          w_stb   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_adr_lo <= '0;
      r_beats  <= 4'd0;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_odat   <= '0;
      r_sel    <= 2'b00;
      r_b4     <= 1'b0;
      r_b8     <= 1'b0;
      r_rdat   <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_adr_lo <= w_adr_lo;
      r_beats  <= w_beats;
      r_cyc    <= w_cyc;
      r_stb    <= w_stb;
      r_we     <= w_we;
      r_adr    <= w_adr;
      r_odat   <= w_odat;
      r_sel    <= w_sel;
      r_b4     <= w_b4;
      r_b8     <= w_b8;
      r_rdat   <= w_rdat;
      r_ack    <= w_ack;
      r_err    <= w_err;
    end
  end

  assign cw_io_o    = r_rdat;
  assign cw_ack     = r_ack;
  assign cw_err     = r_err;
  assign wb_cyc     = r_cyc;
  assign wb_stb     = r_stb;
  assign wb_we      = r_we;
  assign wb_adr     = r_adr;
  assign wb_o_dat   = r_odat;
  assign wb_sel     = r_sel;
  assign wb_4_burst = r_b4;
  assign wb_8_burst = r_b8;

endmodule

`default_nettype wire

// File: tb/tb_wb_decompressor.sv
// ============================================================================
// Module   : tb_wb_decompressor
// Purpose  : Directed self-checking bench for wb_decompressor. A small
//            wishbone slave answers with programmable wait states, data base
//            and an optional erroring beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_decompressor;

  logic        clk;
  logic        rst;
  logic [15:0] cw_io_i;
  logic [15:0] cw_io_o;
  logic        cw_req;
  logic        cw_dir;
  logic        cw_ack;
  logic        cw_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [23:0] wb_adr;
  logic [15:0] wb_o_dat;
  logic [15:0] wb_i_dat;
  logic [1:0]  wb_sel;
  logic        wb_4_burst;
  logic        wb_8_burst;
  logic        wb_ack;
  logic        wb_err;

  int checks;
  int failures;

  // Slave model controls (written by the stimulus) and state (slave only).
  int          s_wait;
  int          s_err_beat;
  logic [15:0] s_base;
  int          s_cnt;
  int          s_beat;

  wb_decompressor #(.RW(16), .WB_ADDR_W(24)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .cw_io_i    (cw_io_i),
    .cw_io_o    (cw_io_o),
    .cw_req     (cw_req),
    .cw_dir     (cw_dir),
    .cw_ack     (cw_ack),
    .cw_err     (cw_err),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_adr     (wb_adr),
    .wb_o_dat   (wb_o_dat),
    .wb_i_dat   (wb_i_dat),
    .wb_sel     (wb_sel),
    .wb_4_burst (wb_4_burst),
    .wb_8_burst (wb_8_burst),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign wb_err   = wb_stb && (s_cnt == s_wait) && ((s_beat + 1) == s_err_beat);
  assign wb_ack   = wb_stb && (s_cnt == s_wait) && ((s_beat + 1) != s_err_beat);
  assign wb_i_dat = s_base + 16'(s_beat);

  always @(posedge clk) begin
    if (!wb_cyc) begin
      s_cnt  <= 0;
      s_beat <= 0;
    end else if (wb_stb) begin
      if (s_cnt == s_wait) begin
        s_cnt  <= 0;
        s_beat <= s_beat + 1;
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    cw_req  = 1'b1;
    cw_dir  = 1'b1;
    cw_io_i = w;
    tick();
    cw_dir  = 1'b0;
  endtask

  task automatic idle_gap();
    cw_req = 1'b0;
    cw_dir = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    cw_req  = 1'b1;
    cw_dir  = 1'b1;
    cw_io_i = 16'hFFFF;
    tick();
    tick();
    rst    = 1'b0;
    cw_req = 1'b0;
    cw_dir = 1'b0;
    checks++;
    if ({wb_cyc, wb_stb, wb_we, cw_ack, cw_err, wb_4_burst, wb_8_burst} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {wb_cyc, wb_stb, wb_we, cw_ack, cw_err, wb_4_burst, wb_8_burst});
    end
    checks++;
    if (wb_adr !== 24'h0 || wb_o_dat !== 16'h0 || wb_sel !== 2'b00 || cw_io_o !== 16'h0) begin
      failures++;
      $display("FAIL reset_data: adr=%h odat=%h sel=%b io=%h want all zero",
               wb_adr, wb_o_dat, wb_sel, cw_io_o);
    end
  endtask

  task automatic test_single_read();
    s_wait = 0; s_err_beat = 0; s_base = 16'hBEEF;
    send(16'h2345);               // cycle 0: word A
    send(16'h1801);               // cycle 1: word C, sel=11, adr hi=01
    // now cycle 2
    checks++;
    if (wb_stb !== 1'b1 || wb_cyc !== 1'b1) begin
      failures++;
      $display("FAIL rd_stb_c2: cyc=%b stb=%b want 1 1", wb_cyc, wb_stb);
    end
    checks++;
    if (wb_adr !== 24'h012345 || wb_we !== 1'b0 || wb_sel !== 2'b11) begin
      failures++;
      $display("FAIL rd_hdr: adr=%h we=%b sel=%b want 012345 0 11", wb_adr, wb_we, wb_sel);
    end
    tick();                       // cycle 3
    checks++;
    if (cw_ack !== 1'b1 || cw_io_o !== 16'hBEEF || wb_stb !== 1'b0 || wb_cyc !== 1'b1) begin
      failures++;
      $display("FAIL rd_ack_c3: ack=%b io=%h stb=%b cyc=%b want 1 beef 0 1",
               cw_ack, cw_io_o, wb_stb, wb_cyc);
    end
    tick();                       // cycle 4
    checks++;
    if (cw_ack !== 1'b0 || wb_cyc !== 1'b0 || cw_io_o !== 16'hBEEF) begin
      failures++;
      $display("FAIL rd_end_c4: ack=%b cyc=%b io=%h want 0 0 beef", cw_ack, wb_cyc, cw_io_o);
    end
    idle_gap();
  endtask

  task automatic test_single_write();
    int stb_n, ack_n, ack_at;
    s_wait = 3; s_err_beat = 0; s_base = 16'h0000;
    stb_n = 0; ack_n = 0; ack_at = -1;
    send(16'h0010);               // A
    send(16'h9800);               // C: we=1 sel=11
    send(16'hA5A5);               // D
    // now cycle 3
    checks++;
    if (wb_stb !== 1'b1 || wb_we !== 1'b1 || wb_o_dat !== 16'hA5A5 || wb_adr !== 24'h000010) begin
      failures++;
      $display("FAIL wr_bus_c3: stb=%b we=%b odat=%h adr=%h want 1 1 a5a5 000010",
               wb_stb, wb_we, wb_o_dat, wb_adr);
    end
    for (int c = 3; c < 15; c++) begin
      if (wb_stb) stb_n++;
      if (cw_ack) begin ack_n++; ack_at = c; end
      tick();
    end
    checks++;
    if (stb_n != 4) begin
      failures++;
      $display("FAIL wr_stb_len: got %0d want 4", stb_n);
    end
    checks++;
    if (ack_n != 1 || ack_at != 7) begin
      failures++;
      $display("FAIL wr_ack: count=%0d at=%0d want 1 at 7", ack_n, ack_at);
    end
    checks++;
    if (wb_cyc !== 1'b0) begin
      failures++;
      $display("FAIL wr_cyc_end: got %b want 0", wb_cyc);
    end
    idle_gap();
  endtask

  task automatic test_read_burst8_wrap();
    logic [23:0] exp_adr [0:7];
    int stb_n, ack_n, cyc_n;
    exp_adr[0] = 24'hFFFFFC; exp_adr[1] = 24'hFFFFFD;
    exp_adr[2] = 24'hFFFFFE; exp_adr[3] = 24'hFFFFFF;
    exp_adr[4] = 24'h000000; exp_adr[5] = 24'h000001;
    exp_adr[6] = 24'h000002; exp_adr[7] = 24'h000003;
    s_wait = 0; s_err_beat = 0; s_base = 16'h1000;
    stb_n = 0; ack_n = 0; cyc_n = 0;
    send(16'hFFFC);
    send(16'h58FF);               // b8=1 sel=11 adr hi=FF
    for (int c = 2; c < 40; c++) begin
      if (wb_stb && stb_n < 8) begin
        checks++;
        if (wb_adr !== exp_adr[stb_n]) begin
          failures++;
          $display("FAIL b8_adr[%0d]: got %h want %h", stb_n, wb_adr, exp_adr[stb_n]);
        end
        stb_n++;
      end
      if (cw_ack) begin
        checks++;
        if (cw_io_o !== 16'h1000 + 16'(ack_n)) begin
          failures++;
          $display("FAIL b8_data[%0d]: got %h want %h", ack_n, cw_io_o, 16'h1000 + 16'(ack_n));
        end
        ack_n++;
      end
      if (wb_cyc) begin
        cyc_n++;
        if (wb_8_burst !== 1'b1) begin
          checks++;
          failures++;
          $display("FAIL b8_hint: got %b want 1", wb_8_burst);
        end
      end
      tick();
    end
    checks++;
    if (stb_n != 8 || ack_n != 8) begin
      failures++;
      $display("FAIL b8_counts: stb=%0d ack=%0d want 8 8", stb_n, ack_n);
    end
    checks++;
    if (cyc_n != 16) begin
      failures++;
      $display("FAIL b8_cyc_len: got %0d want 16", cyc_n);
    end
    idle_gap();
  endtask

  task automatic test_write_burst_err();
    logic [15:0] dwords [0:3];
    int stb_n, ack_n, err_n, dn;
    logic pend;
    dwords[0] = 16'h1111; dwords[1] = 16'h2222; dwords[2] = 16'h3333; dwords[3] = 16'h4444;
    s_wait = 0; s_err_beat = 2; s_base = 16'h0000;
    stb_n = 0; ack_n = 0; err_n = 0; dn = 1; pend = 1'b0;
    send(16'h0100);
    send(16'hB800);               // we=1 b4=1 sel=11
    send(dwords[0]);
    for (int c = 3; c < 25; c++) begin
      if (pend && dn < 4) begin
        cw_dir  = 1'b1;
        cw_io_i = dwords[dn];
        dn++;
      end else begin
        cw_dir = 1'b0;
      end
      pend = 1'b0;
      if (wb_stb) begin
        if (stb_n == 1) begin
          checks++;
          if (wb_o_dat !== 16'h2222 || wb_adr !== 24'h000101) begin
            failures++;
            $display("FAIL wb4_beat2: odat=%h adr=%h want 2222 000101", wb_o_dat, wb_adr);
          end
        end
        stb_n++;
      end
      if (cw_ack) begin ack_n++; pend = 1'b1; end
      if (cw_err) begin
        err_n++;
        checks++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
          failures++;
          $display("FAIL wb4_err_bus: cyc=%b stb=%b want 0 0", wb_cyc, wb_stb);
        end
      end
      tick();
    end
    cw_dir = 1'b0;
    checks++;
    if (ack_n != 1 || err_n != 1) begin
      failures++;
      $display("FAIL wb4_pulses: ack=%0d err=%0d want 1 1", ack_n, err_n);
    end
    checks++;
    if (stb_n != 2) begin
      failures++;
      $display("FAIL wb4_beats: got %0d want 2", stb_n);
    end
    idle_gap();
  endtask

  task automatic test_abort_in_bus();
    int ack_n;
    s_wait = 1; s_err_beat = 0; s_base = 16'h7777;
    ack_n = 0;
    send(16'h0ABC);
    send(16'h1800);
    tick();                       // cycle 3: slave acks now, master drops req
    cw_req = 1'b0;
    tick();                       // cycle 4
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || cw_ack !== 1'b0 || wb_adr !== 24'h0) begin
      failures++;
      $display("FAIL abort_bus: cyc=%b stb=%b ack=%b adr=%h want 0 0 0 000000",
               wb_cyc, wb_stb, cw_ack, wb_adr);
    end
    for (int c = 0; c < 5; c++) begin
      if (cw_ack || cw_err) ack_n++;
      tick();
    end
    checks++;
    if (ack_n != 0) begin
      failures++;
      $display("FAIL abort_quiet: got %0d pulses want 0", ack_n);
    end
    // A fresh request completes normally.
    s_wait = 0; s_base = 16'h5555;
    send(16'h0ABC);
    send(16'h1800);
    tick();
    checks++;
    if (cw_ack !== 1'b1 || cw_io_o !== 16'h5555) begin
      failures++;
      $display("FAIL abort_recover: ack=%b io=%h want 1 5555", cw_ack, cw_io_o);
    end
    idle_gap();
  endtask

  task automatic test_reset_in_resp();
    int ack_n, post_n;
    s_wait = 0; s_err_beat = 0; s_base = 16'h2000;
    ack_n = 0; post_n = 0;
    send(16'h0200);
    send(16'h3800);               // b4=1 read
    for (int c = 2; c < 20 && ack_n < 2; c++) begin
      if (cw_ack) ack_n++;
      if (ack_n < 2) tick();
    end
    checks++;
    if (ack_n != 2) begin
      failures++;
      $display("FAIL rst_resp_reach: got %0d acks want 2", ack_n);
    end
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    cw_req = 1'b0;
    checks++;
    if ({wb_cyc, wb_stb, cw_ack, wb_4_burst} !== 4'b0 || wb_adr !== 24'h0 || cw_io_o !== 16'h0) begin
      failures++;
      $display("FAIL rst_resp_vals: cyc=%b stb=%b ack=%b b4=%b adr=%h io=%h want zeros",
               wb_cyc, wb_stb, cw_ack, wb_4_burst, wb_adr, cw_io_o);
    end
    for (int c = 0; c < 10; c++) begin
      if (cw_ack || wb_stb) post_n++;
      tick();
    end
    checks++;
    if (post_n != 0) begin
      failures++;
      $display("FAIL rst_resp_quiet: got %0d activity cycles want 0", post_n);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    cw_req     = 1'b0;
    cw_dir     = 1'b0;
    cw_io_i    = 16'h0;
    s_wait     = 0;
    s_err_beat = 0;
    s_base     = 16'h0;
    test_reset();
    test_single_read();
    test_single_write();
    test_read_burst8_wrap();
    test_write_burst_err();
    test_abort_in_bus();
    test_reset_in_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
